muldiv_ctrl: RTL and testbench

Multi-cycle HI/LO controller sitting beside the EX stage. It sequences the shared multiplier (fixed-latency pipeline) and the iterative divider (start/ready handshake), raises the EX stall request while an operation is in flight, and owns the architectural HI/LO registers. It also executes single-cycle MTHI/MTLO writes. EX supplies the decoded op and operands; the stall controller consumes `stallreq`.

---
 rtl/md_pkg.sv | 21 ++
 rtl/muldiv_ctrl_if.sv | 32 +++
 rtl/md_hilo_reg.sv | 25 ++
 rtl/muldiv_ctrl.sv | 133 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM states and widths shared by the HI/LO
// multiply/divide controller and its register pair.
package md_pkg;

  localparam int MD_HILO_W = 64;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: bundle between the HI/LO controller (master)
// and the shared multiplier / iterative divider (slave).
interface muldiv_ctrl_if;
  import md_pkg::*;

  logic                 mul_signed;
  logic [31:0]          mul_ina;
  logic [31:0]          mul_inb;
  logic [MD_HILO_W-1:0] mul_result;
  logic                 div_start;
  logic                 div_signed;
  logic                 div_annul;
  logic [31:0]          div_op1;
  logic [31:0]          div_op2;
  logic [MD_HILO_W-1:0] div_result;
  logic                 div_ready;

  modport master (
    output mul_signed, mul_ina, mul_inb,
    output div_start, div_signed, div_annul,
    output div_op1, div_op2,
    input  mul_result, div_result, div_ready
  );

  modport slave (
    input  mul_signed, mul_ina, mul_inb,
    input  div_start, div_signed, div_annul,
    input  div_op1, div_op2,
    output mul_result, div_result, div_ready
  );

endinterface

// File: rtl/md_hilo_reg.sv
// md_hilo_reg: architectural HI/LO pair, 64-bit write port,
// independent half write enables.
module md_hilo_reg
  import md_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_hi,
  input  logic                 we_lo,
  input  logic [MD_HILO_W-1:0] wdata,
  output logic [31:0]          hi,
  output logic [31:0]          lo
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (we_hi) hi <= wdata[MD_HILO_W-1:MD_HILO_W/2];
      if (we_lo) lo <= wdata[MD_HILO_W/2-1:0];
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences multiplier/divider, stalls EX, owns HI/LO.
// Optional: MD_DIVZERO_BYPASS_EN resolves divide-by-zero locally.
module muldiv_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          op_valid,
  input  logic [2:0]    op,
  input  logic [31:0]   src_a,
  input  logic [31:0]   src_b,
  output logic          stallreq,
  output logic [31:0]   hi,
  output logic [31:0]   lo,
  muldiv_ctrl_if.master md
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e            state;
  logic [CW-1:0]        cnt;
  logic                 is_mul, is_div, is_mthi, is_mtlo;
  logic                 dz, idle_go;
  logic                 issue_mul, issue_div, issue_dz;
  logic                 mul_fin, div_fin;
  logic                 mul_act, div_act;
  logic                 we_hi, we_lo;
  logic [MD_HILO_W-1:0] wdata;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      (op == MD_MULT) || (op == MD_MULTU): is_mul  = 1'b1;
      (op == MD_DIV)  || (op == MD_DIVU):  is_div  = 1'b1;
      (op == MD_MTHI):                     is_mthi = 1'b1;
      (op == MD_MTLO):                     is_mtlo = 1'b1;
      default: ;
    endcase
  end

`ifdef MD_DIVZERO_BYPASS_EN
  assign dz = (src_b == '0);
`else
  assign dz = 1'b0;
`endif

  // resetn gates issue so nothing is requested while reset is held
  assign idle_go   = resetn && !flush && op_valid && (state == IDLE);
  assign issue_mul = idle_go && is_mul;
  assign issue_div = idle_go && is_div && !dz;
  assign issue_dz  = idle_go && is_div && dz;

  assign mul_fin = !flush &&
                   ((MUL_LAT == 1 && issue_mul) ||
                    (state == MUL_WAIT && cnt == CW'(1)));
  assign div_fin = !flush && (state == DIV_RUN) && md.div_ready;

  assign stallreq = !flush &&
                    (issue_mul || issue_div || issue_dz ||
                     state == MUL_WAIT || state == DIV_RUN);

  assign mul_act       = issue_mul || (!flush && state == MUL_WAIT);
  assign md.mul_signed = mul_act && (op == MD_MULT);
  assign md.mul_ina    = mul_act ? src_a : '0;
  assign md.mul_inb    = mul_act ? src_b : '0;

  assign div_act       = (state == DIV_RUN);
  assign md.div_start  = div_act && !flush;
  assign md.div_annul  = div_act && flush;
  assign md.div_signed = div_act && (op == MD_DIV);
  assign md.div_op1    = div_act ? src_a : '0;
  assign md.div_op2    = div_act ? src_b : '0;

  assign we_hi = mul_fin || div_fin || issue_dz || (idle_go && is_mthi);
  assign we_lo = mul_fin || div_fin || issue_dz || (idle_go && is_mtlo);

  always_comb begin
    wdata = {src_a, src_a};
    unique case (1'b1)
      mul_fin:  wdata = md.mul_result;
      div_fin:  wdata = md.div_result;
      issue_dz: wdata = {src_a, 32'hFFFF_FFFF};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue_mul) begin
            cnt   <= CW'(MUL_LAT - 1);
            state <= (MUL_LAT == 1) ? DONE : MUL_WAIT;
          end else if (issue_div) begin
            state <= DIV_RUN;
          end else if (issue_dz) begin
            state <= DONE;
          end
        end
        MUL_WAIT: begin
          cnt <= cnt - 1'b1;
          if (mul_fin) state <= DONE;
        end
        DIV_RUN:  if (div_fin) state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  md_hilo_reg u_hilo (
    .clk   (clk),
    .rst_n (resetn),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table, corner sequences and random ops
// against an arithmetic HI/LO reference model.
module tb_muldiv_ctrl;
  import md_pkg::*;

  localparam int ML      = 2;
  localparam int DIV_CYC = 33;
  localparam logic [31:0] DZ_HI = 32'hD1D1_0000;
  localparam logic [31:0] DZ_LO = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq;
  logic [31:0] hi, lo;
  logic        inj_ready;
  logic [7:0]  dcnt;
  logic [63:0] mreg;

  int nvec = 0;
  int nmis = 0;

  muldiv_ctrl_if u_if ();

  muldiv_ctrl #(.MUL_LAT(ML)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .stallreq (stallreq),
    .hi       (hi),
    .lo       (lo),
    .md       (u_if)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mul_math(bit s, logic [31:0] a, logic [31:0] b);
    longint x, y;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      return 64'(x * y);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] div_math(bit s, logic [31:0] a, logic [31:0] b);
    longint x, y, q, r;
    if (b == 0) return {DZ_HI, DZ_LO};
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // multiplier: result sampled by the controller at the ML-th edge
  always_ff @(posedge clk)
    mreg <= mul_math(u_if.mul_signed, u_if.mul_ina, u_if.mul_inb);
  assign u_if.mul_result = mreg;

  // divider: ready on the DIV_CYC-th cycle of div_start
  always_ff @(posedge clk)
    if (!resetn || !u_if.div_start) dcnt <= '0;
    else dcnt <= dcnt + 8'd1;
  assign u_if.div_ready  = (u_if.div_start && dcnt == 8'(DIV_CYC - 1)) || inj_ready;
  assign u_if.div_result = div_math(u_if.div_signed, u_if.div_op1, u_if.div_op2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] h, inout logic [31:0] l,
                        output int st, output bit started);
    st = 0;
    started = 0;
    if (o == MD_MULT || o == MD_MULTU) begin
      {h, l} = mul_math(o == MD_MULT, a, b);
      st = ML;
    end else if (o == MD_DIV || o == MD_DIVU) begin
`ifdef MD_DIVZERO_BYPASS_EN
      if (b == 0) begin
        h = a;
        l = 32'hFFFF_FFFF;
        st = 1;
      end else begin
        {h, l} = div_math(o == MD_DIV, a, b);
        st = DIV_CYC + 1;
        started = 1;
      end
`else
      {h, l} = div_math(o == MD_DIV, a, b);
      st = DIV_CYC + 1;
      started = 1;
`endif
    end else if (o == MD_MTHI) begin
      h = a;
    end else begin
      l = a;
    end
  endtask

  // called just after a rising edge; returns just after the edge
  // that ends the op's last (non-stalled) EX cycle
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output bit started);
    bit run;
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    stalls = 0;
    started = 0;
    run = 1;
    while (run) begin
      @(negedge clk);
      if (u_if.div_start) started = 1;
      if (stallreq && stalls < 200) begin
        stalls++;
        @(posedge clk);
        #1;
      end else begin
        run = 0;
      end
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          est;
    bit          estart;
  } vec_t;

  vec_t tv[7];

  initial begin
    int st, est;
    bit sd, esd;
    logic [31:0] mhi, mlo;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    tv[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, ML, 1'b0};
    tv[1] = '{MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'd2, 32'hFFFF_FFFA, ML, 1'b0};
    tv[2] = '{MD_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 1'b1};
    tv[3] = '{MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b1};
    tv[4] = '{MD_MTHI,  32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'd14, 0, 1'b0};
    tv[5] = '{MD_MTLO,  32'h1234_5678, 32'd0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0};
`ifdef MD_DIVZERO_BYPASS_EN
    tv[6] = '{MD_DIV,   32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 1'b0};
`else
    tv[6] = '{MD_DIV,   32'd5, 32'd0, DZ_HI, DZ_LO, 34, 1'b1};
`endif

    resetn = 1'b0;
    flush = 1'b0;
    op_valid = 1'b0;
    op = '0;
    src_a = '0;
    src_b = '0;
    inj_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {63'b0, stallreq}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_ctl", {61'b0, u_if.div_start, u_if.div_annul, u_if.mul_signed}, 64'd0);
    chk("rst_ops", {u_if.mul_ina, u_if.div_op1}, 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, st, sd);
      chk($sformatf("tv%0d_hi", i), {32'b0, hi}, {32'b0, tv[i].ehi});
      chk($sformatf("tv%0d_lo", i), {32'b0, lo}, {32'b0, tv[i].elo});
      chk($sformatf("tv%0d_stall", i), 64'(st), 64'(tv[i].est));
      chk($sformatf("tv%0d_start", i), {63'b0, sd}, {63'b0, tv[i].estart});
    end

    // flush at cycle 10 of a division
    op_valid = 1'b1;
    op = MD_DIV;
    src_a = 32'd1000;
    src_b = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_annul", {63'b0, u_if.div_annul}, 64'd1);
    chk("fl_stall", {63'b0, stallreq}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    chk("fl_annul_off", {62'b0, u_if.div_annul, u_if.div_start}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    inj_ready = 1'b1;
    @(posedge clk);
    #1;
    inj_ready = 1'b0;
    chk("fl_hilo", {hi, lo}, {tv[6].ehi, tv[6].elo});

    // flush and div_ready in the same cycle
    op_valid = 1'b1;
    op = MD_DIVU;
    src_a = 32'd77;
    src_b = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    inj_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    inj_ready = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    chk("flrdy_hilo", {hi, lo}, {tv[6].ehi, tv[6].elo});
    chk("flrdy_stall", {63'b0, stallreq}, 64'd0);

    // async reset during MUL_WAIT
    @(posedge clk);
    #1;
    op_valid = 1'b1;
    op = MD_MULT;
    src_a = 32'd9;
    src_b = 32'd9;
    @(negedge clk);
    chk("rm_issue", {63'b0, stallreq}, 64'd1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rm_stall", {63'b0, stallreq}, 64'd0);
    chk("rm_hilo", {hi, lo}, 64'd0);
    op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    mhi = '0;
    mlo = '0;
    ref_op(MD_MULT, 32'd6, 32'd7, mhi, mlo, est, esd);
    do_op(MD_MULT, 32'd6, 32'd7, st, sd);
    chk("rm_mul", {hi, lo}, {mhi, mlo});
    chk("rm_mul_stall", 64'(st), 64'(est));

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i == 7) begin
        ro = MD_DIV;
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      ref_op(ro, ra, rb, mhi, mlo, est, esd);
      do_op(ro, ra, rb, st, sd);
      chk($sformatf("rnd%0d_op%0d_hilo", i, ro), {hi, lo}, {mhi, mlo});
      chk($sformatf("rnd%0d_op%0d_stall", i, ro), 64'(st), 64'(est));
      chk($sformatf("rnd%0d_op%0d_start", i, ro), {63'b0, sd}, {63'b0, esd});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
